banked_memory: RTL and testbench

BANKED_MEMORY -- requirements
Module: banked_memory

---
 rtl/banked_memory.sv | 208 ++++++++++++++++++++
 tb/tb_banked_memory.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_memory.sv
// Byte-addressed, word-wide RAM with per-lane write enables. Unaligned accesses are
// either split across two adjacent words over two cycles or rejected with err.
module banked_memory #(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 16,
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                dbg_state
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int WORDS  = 1 << WORD_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Second-half context of a split access, captured on the acceptance edge.
    logic              op_q, op_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [WORDS];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and every accepted request gets
    // exactly one single-cycle rsp_valid pulse (err set when it was rejected).
    logic accept, off_nz, reject;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign off_nz    = (addr[OFF_W-1:0] != '0);
    assign reject    = accept && off_nz && !ALLOW_UNALIGNED;

    logic              acc_op;
    logic [OFF_W-1:0]  acc_off;
    logic [WORD_W-1:0] acc_word;
    logic [DATA_W-1:0] acc_wdata;
    logic [NB-1:0]     acc_be;
    logic              acc_second;
    logic              acc_en;

    always_comb begin
        if (state_q == SPLIT) begin
            acc_op     = op_q;
            acc_off    = off_q;
            acc_word   = word_q;
            acc_wdata  = wdata_q;
            acc_be     = be_q;
            acc_second = 1'b1;
            acc_en     = !reset;
        end else begin
            acc_op     = op;
            acc_off    = addr[OFF_W-1:0];
            acc_word   = addr[ADDR_W-1:OFF_W];
            acc_wdata  = wdata;
            acc_be     = be;
            acc_second = 1'b0;
            acc_en     = accept && !reject;
        end
    end

    // Request byte i lives in lane (i + off) mod NB; the first half owns lanes
    // off..NB-1 of word w, the second half lanes 0..off-1 of word w+1.
    logic [NB-1:0]     lane_sel;
    logic [NB-1:0]     lane_we;
    logic [DATA_W-1:0] lane_wdata;
    logic [OFF_W-1:0]  src;

    always_comb begin
        lane_sel   = '0;
        lane_we    = '0;
        lane_wdata = '0;
        src        = '0;
        for (int l = 0; l < NB; l++) begin
            src         = OFF_W'(l) - acc_off;
            lane_sel[l] = acc_second ? (OFF_W'(l) < acc_off) : (OFF_W'(l) >= acc_off);
            lane_we[l]  = acc_en && acc_op && lane_sel[l] && acc_be[src];
            lane_wdata[8*l +: 8] = acc_wdata[8*src +: 8];
        end
    end

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic [OFF_W-1:0]  rd_lane;

    assign rd_word = mem_q[acc_word];

    always_comb begin
        merged  = hold_q;
        rd_lane = '0;
        for (int i = 0; i < NB; i++) begin
            rd_lane = OFF_W'(i) + acc_off;
            if (lane_sel[rd_lane]) begin
                merged[8*i +: 8] = rd_word[8*rd_lane +: 8];
            end
        end
    end

    // Storage has no reset so contents survive it.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NB; l++) begin
            if (lane_we[l]) begin
                mem_q[acc_word][8*l +: 8] <= lane_wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            off_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            hold_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && off_nz && ALLOW_UNALIGNED) state_d = SPLIT;
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_d = 1'b0;
        rdata_d     = '0;
        err_d       = 1'b0;
        op_d        = op_q;
        off_d       = off_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else if (off_nz) begin
                        op_d    = op;
                        off_d   = addr[OFF_W-1:0];
                        word_d  = addr[ADDR_W-1:OFF_W] + WORD_W'(1);
                        wdata_d = wdata;
                        be_d    = be;
                        hold_d  = merged;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rdata_d     = op ? '0 : merged;
                    end
                end
            end
            SPLIT: begin
                rsp_valid_d = 1'b1;
                rdata_d     = op_q ? '0 : merged;
            end
            default: ;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_banked_memory.sv
// Bench for banked_memory: one instance splits unaligned accesses, a second rejects
// them. Reads are checked against a byte-array model of memory.
module tb_banked_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_a = 1'b0;
    logic        req_valid_b = 1'b0;
    logic        op = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;

    logic        req_ready_a, rsp_valid_a, err_a, dbg_a;
    logic [15:0] rdata_a;
    logic        req_ready_b, rsp_valid_b, err_b, dbg_b;
    logic [15:0] rdata_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem   [65536];
    bit         ref_known [65536];

    always #5 clk = ~clk;

    banked_memory #(.DATA_W(16), .ADDR_W(16), .ALLOW_UNALIGNED(1'b1)) u_split (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .op(op), .addr(addr), .wdata(wdata), .be(be), .rsp_valid(rsp_valid_a),
        .rdata(rdata_a), .err(err_a), .dbg_state(dbg_a)
    );

    banked_memory #(.DATA_W(16), .ADDR_W(16), .ALLOW_UNALIGNED(1'b0)) u_reject (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .op(op), .addr(addr), .wdata(wdata), .be(be), .rsp_valid(rsp_valid_b),
        .rdata(rdata_b), .err(err_b), .dbg_state(dbg_b)
    );

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
        for (int i = 0; i < 2; i++) begin
            if (b[i]) begin
                ref_mem[16'(a + i)]   = d[8*i +: 8];
                ref_known[16'(a + i)] = 1'b1;
            end
        end
    endfunction

    function automatic void model_read(input logic [15:0] a, output logic [15:0] d, output logic [15:0] m);
        d = '0;
        m = '0;
        for (int i = 0; i < 2; i++) begin
            if (ref_known[16'(a + i)]) begin
                d[8*i +: 8] = ref_mem[16'(a + i)];
                m[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    // Issue one request to instance a (tgt=0) or b (tgt=1) and collect its response.
    task automatic req(input bit tgt, input bit o, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] b, output logic [15:0] rd, output bit e, output int lat,
                       output bit rdy1, output bit rdy_rsp, output bit tail, output logic [15:0] tail_rd);
        int n;
        @(negedge clk);
        op = o; addr = a; wdata = d; be = b;
        if (tgt) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        n = 0;
        while (!(tgt ? req_ready_b : req_ready_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL req_ready_timeout: got ready=0 for %0d cycles exp 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        rdy1 = tgt ? req_ready_b : req_ready_a;
        lat = 1;
        while (!(tgt ? rsp_valid_b : rsp_valid_a) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd      = tgt ? rdata_b : rdata_a;
        e       = tgt ? err_b : err_a;
        rdy_rsp = tgt ? req_ready_b : req_ready_a;
        @(negedge clk);
        tail    = tgt ? rsp_valid_b : rsp_valid_a;
        tail_rd = tgt ? rdata_b : rdata_a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = 1'b1; addr = 16'h0040; wdata = 16'h1111; be = 2'b11;
        req_valid_a = 1'b1;
        req_valid_b = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (req_ready_a !== 1'b0 || req_ready_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b/%b exp 0/0", req_ready_a, req_ready_b);
        end
        n_tests++;
        if (rsp_valid_a !== 1'b0 || rdata_a !== 16'h0 || err_a !== 1'b0 || dbg_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b d=%h e=%b s=%b exp 0", rsp_valid_a, rdata_a, err_a, dbg_a);
        end
        n_tests++;
        if (rsp_valid_b !== 1'b0 || rdata_b !== 16'h0 || err_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs_b: got v=%b d=%h e=%b exp 0", rsp_valid_b, rdata_b, err_b);
        end
        reset = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: got v=%b rdy=%b exp v=0 rdy=1", rsp_valid_a, req_ready_a);
        end
    endtask

    task automatic test_reset_retain();
        logic [15:0] rd, trd; bit e, r1, rr, t; int lat;
        req(0, 1'b1, 16'h0040, 16'hCAFE, 2'b11, rd, e, lat, r1, rr, t, trd);
        model_write(16'h0040, 16'hCAFE, 2'b11);
        @(negedge clk);
        reset = 1'b1;
        op = 1'b1; addr = 16'h0040; wdata = 16'h1111; be = 2'b11;
        req_valid_a = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid_a = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_accept: got rsp_valid=%b exp 0", rsp_valid_a);
        end
        req(0, 1'b0, 16'h0040, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'hCAFE) begin
            n_fail++; $display("FAIL reset_retain: got %h exp cafe", rd);
        end
    endtask

    task automatic test_directed();
        logic [15:0] rd, trd; bit e, r1, rr, t; int lat;
        req(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, rd, e, lat, r1, rr, t, trd);
        model_write(16'h0010, 16'hBEEF, 2'b11);
        n_tests++;
        if (lat != 1 || rd !== 16'h0 || e !== 1'b0 || t !== 1'b0) begin
            n_fail++; $display("FAIL wr_aligned_ack: got lat=%0d rd=%h err=%b tail=%b exp 1/0/0/0", lat, rd, e, t);
        end
        req(0, 1'b0, 16'h0010, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (lat != 1 || rd !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_aligned: got lat=%0d rd=%h exp 1/beef", lat, rd);
        end
        req(0, 1'b1, 16'h0011, 16'h1234, 2'b11, rd, e, lat, r1, rr, t, trd);
        model_write(16'h0011, 16'h1234, 2'b11);
        n_tests++;
        if (lat != 2 || r1 !== 1'b0 || rr !== 1'b1 || rd !== 16'h0 || t !== 1'b0) begin
            n_fail++; $display("FAIL wr_split: got lat=%0d rdy1=%b rdy2=%b rd=%h tail=%b exp 2/0/1/0/0", lat, r1, rr, rd, t);
        end
        req(0, 1'b0, 16'h0010, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'h34EF) begin
            n_fail++; $display("FAIL rd_after_split_lo: got %h exp 34ef", rd);
        end
        req(0, 1'b0, 16'h0012, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd[7:0] !== 8'h12) begin
            n_fail++; $display("FAIL rd_after_split_hi: got %h exp 12", rd[7:0]);
        end
        req(0, 1'b1, 16'hFFFF, 16'hA55A, 2'b11, rd, e, lat, r1, rr, t, trd);
        model_write(16'hFFFF, 16'hA55A, 2'b11);
        req(0, 1'b0, 16'hFFFE, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd[15:8] !== 8'h5A) begin
            n_fail++; $display("FAIL wrap_top: got %h exp 5a", rd[15:8]);
        end
        req(0, 1'b0, 16'h0000, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd[7:0] !== 8'hA5) begin
            n_fail++; $display("FAIL wrap_bottom: got %h exp a5", rd[7:0]);
        end
        req(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, rd, e, lat, r1, rr, t, trd);
        model_write(16'h0010, 16'hBEEF, 2'b11);
        req(0, 1'b1, 16'h0010, 16'h0000, 2'b01, rd, e, lat, r1, rr, t, trd);
        model_write(16'h0010, 16'h0000, 2'b01);
        req(0, 1'b0, 16'h0010, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'hBE00) begin
            n_fail++; $display("FAIL partial_write: got %h exp be00", rd);
        end
        req(0, 1'b1, 16'h0010, 16'h1234, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (lat != 1 || rd !== 16'h0) begin
            n_fail++; $display("FAIL be0_ack: got lat=%0d rd=%h exp 1/0", lat, rd);
        end
        req(0, 1'b0, 16'h0010, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'hBE00) begin
            n_fail++; $display("FAIL be0_noop: got %h exp be00", rd);
        end
    endtask

    task automatic test_split_reset();
        logic [15:0] rd, trd; bit e, r1, rr, t; int lat;
        req(0, 1'b1, 16'h0020, 16'h0000, 2'b11, rd, e, lat, r1, rr, t, trd);
        req(0, 1'b1, 16'h0022, 16'h5566, 2'b11, rd, e, lat, r1, rr, t, trd);
        model_write(16'h0020, 16'h0000, 2'b11);
        model_write(16'h0022, 16'h5566, 2'b11);
        @(negedge clk);
        op = 1'b1; addr = 16'h0021; wdata = 16'h7788; be = 2'b11;
        req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        n_tests++;
        if (dbg_a !== 1'b1 || req_ready_a !== 1'b0) begin
            n_fail++; $display("FAIL split_state: got state=%b rdy=%b exp 1/0", dbg_a, req_ready_a);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_write(16'h0021, 16'h0088, 2'b01);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (rsp_valid_a !== 1'b0 || dbg_a !== 1'b0) begin
                n_fail++; $display("FAIL split_reset_rsp: got v=%b state=%b exp 0/0", rsp_valid_a, dbg_a);
            end
            @(negedge clk);
        end
        req(0, 1'b0, 16'h0020, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'h8800) begin
            n_fail++; $display("FAIL split_reset_first: got %h exp 8800", rd);
        end
        req(0, 1'b0, 16'h0022, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'h5566) begin
            n_fail++; $display("FAIL split_reset_second: got %h exp 5566", rd);
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, trd, a, d, exp, m; logic [1:0] b; bit o, e, r1, rr, t; int lat;
        for (int k = 0; k < 200; k++) begin
            o = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                            : 16'($urandom_range(0, 47));
            d = 16'($urandom);
            b = 2'($urandom_range(0, 3));
            model_read(a, exp, m);
            req(0, o, a, d, b, rd, e, lat, r1, rr, t, trd);
            if (o) begin
                model_write(a, d, b);
                exp = 16'h0;
                m   = 16'hFFFF;
            end
            n_tests++;
            if (lat != (a[0] ? 2 : 1) || r1 !== !a[0] || e !== 1'b0) begin
                n_fail++; $display("FAIL rand_timing @%h: got lat=%0d rdy1=%b err=%b exp %0d/%b/0", a, lat, r1, e, a[0] ? 2 : 1, !a[0]);
            end
            n_tests++;
            if (((rd ^ exp) & m) !== 16'h0) begin
                n_fail++; $display("FAIL rand_data op=%b @%h: got %h exp %h mask %h", o, a, rd, exp, m);
            end
            n_tests++;
            if (t !== 1'b0 || trd !== 16'h0) begin
                n_fail++; $display("FAIL rand_pulse: got tail_valid=%b tail_rdata=%h exp 0/0", t, trd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        logic [15:0] a, d, exp, m; logic [1:0] b; bit o;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (rsp_valid_a !== 1'b1 || rdata_a !== exp) begin
                    n_fail++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h exp 1/%h", k - 1, rsp_valid_a, rdata_a, exp);
                end
            end
            if (k < 24) begin
                n_tests++;
                if (req_ready_a !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready[%0d]: got %b exp 1", k, req_ready_a);
                end
                o = (k < 8) ? 1'b1 : 1'($urandom_range(0, 1));
                a = 16'h0100 + 16'(2 * ((k < 8) ? k : $urandom_range(0, 7)));
                d = 16'($urandom);
                b = (k < 8) ? 2'b11 : 2'($urandom_range(0, 3));
                if (k == 8) begin o = 1'b1; a = 16'h0104; b = 2'b11; end
                if (k == 9) begin o = 1'b0; a = 16'h0104; end
                op = o; addr = a; wdata = d; be = b;
                req_valid_a = 1'b1;
                if (o) begin
                    model_write(a, d, b);
                    exp_q.push_back(16'h0);
                end else begin
                    model_read(a, exp, m);
                    exp_q.push_back(exp);
                end
            end else begin
                req_valid_a = 1'b0;
            end
        end
    endtask

    task automatic test_reject();
        logic [15:0] rd, trd; bit e, r1, rr, t; int lat;
        logic [15:0] exp_q[$];
        logic [15:0] exp;
        req(1, 1'b1, 16'h0002, 16'h1122, 2'b11, rd, e, lat, r1, rr, t, trd);
        req(1, 1'b1, 16'h0004, 16'h3344, 2'b11, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (lat != 1 || e !== 1'b0) begin
            n_fail++; $display("FAIL rej_aligned_wr: got lat=%0d err=%b exp 1/0", lat, e);
        end
        req(1, 1'b0, 16'h0003, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (lat != 1 || e !== 1'b1 || rd !== 16'h0 || r1 !== 1'b1 || t !== 1'b0) begin
            n_fail++; $display("FAIL rej_read: got lat=%0d err=%b rd=%h rdy=%b tail=%b exp 1/1/0/1/0", lat, e, rd, r1, t);
        end
        req(1, 1'b1, 16'h0003, 16'hFFFF, 2'b11, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (lat != 1 || e !== 1'b1) begin
            n_fail++; $display("FAIL rej_write: got lat=%0d err=%b exp 1/1", lat, e);
        end
        req(1, 1'b0, 16'h0002, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'h1122 || e !== 1'b0) begin
            n_fail++; $display("FAIL rej_unchanged_lo: got %h err=%b exp 1122/0", rd, e);
        end
        req(1, 1'b0, 16'h0004, 16'h0, 2'b00, rd, e, lat, r1, rr, t, trd);
        n_tests++;
        if (rd !== 16'h3344) begin
            n_fail++; $display("FAIL rej_unchanged_hi: got %h exp 3344", rd);
        end
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (rsp_valid_b !== 1'b1 || err_b !== 1'b0 || rdata_b !== exp) begin
                    n_fail++; $display("FAIL rej_b2b[%0d]: got v=%b e=%b d=%h exp 1/0/%h", k - 1, rsp_valid_b, err_b, rdata_b, exp);
                end
            end
            if (k < 4) begin
                op = 1'b0; be = 2'b00;
                addr = (k % 2 == 0) ? 16'h0002 : 16'h0004;
                exp_q.push_back((k % 2 == 0) ? 16'h1122 : 16'h3344);
                req_valid_b = 1'b1;
            end else begin
                req_valid_b = 1'b0;
            end
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid_b !== 1'b0 || rdata_b !== 16'h0) begin
            n_fail++; $display("FAIL rej_b2b_end: got v=%b d=%h exp 0/0", rsp_valid_b, rdata_b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_retain();
        test_directed();
        test_split_reset();
        test_random();
        test_back_to_back();
        test_reject();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
